// File: rtl/moore_seqgen_if.sv
// Handshake and serial-stream bundle for the moore_seqgen pattern transmitter.
//
// Signals:
//   start   request to begin a transmission (driven by the controller)
//   pat_in  PAT_W-bit pattern, latched on an accepted start
//   rep_in  REP_W-bit frame count, latched on an accepted start (0 acts as 1)
//   abort   cancels an active transmission
//   dout    serial data bit, MSB-first
//   dvalid  high while dout carries a pattern bit
//   busy    high whenever the transmitter is not idle
//   done    one-cycle pulse after the last bit of the last frame
//
// Modports: master = controller / testbench side, slave = transmitter side.
interface moore_seqgen_if #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pat_in;
    logic [REP_W-1:0] rep_in;
    logic             abort;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    modport master (
        output start, pat_in, rep_in, abort,
        input  dout, dvalid, busy, done
    );

    modport slave (
        input  start, pat_in, rep_in, abort,
        output dout, dvalid, busy, done
    );
endinterface

// File: rtl/moore_seqgen.sv
// Serial pattern transmitter that feeds the Moore sequence detectors.
// On an accepted start it latches a PAT_W-bit pattern and a frame count,
// then shifts the pattern out MSB-first, one bit per clock, repeating the
// frame the requested number of times with GAP_CYC idle cycles in between.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    moore_seqgen_if slave modport (start/pat_in/rep_in/abort in,
//          dout/dvalid/busy/done out; all outputs come straight from flops)
module moore_seqgen #(
    parameter int PAT_W   = 4,
    parameter int REP_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic           clk,
    input  logic           reset,
    moore_seqgen_if.slave  bus
);

    localparam int BC_W = $clog2(PAT_W);
    localparam int GC_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(PAT_W - 1);
    localparam logic [GC_W-1:0]  GAP_LAST  = GC_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [REP_W-1:0] ONE_FRAME = REP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        FIN
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] pat_hold;
    logic [BC_W-1:0]  bitcnt;
    logic [REP_W-1:0] frames_left;
    logic [GC_W-1:0]  gapcnt;
    logic             dvalid_q;
    logic             busy_q;
    logic             done_q;

    // The untouched copy of the pattern used to reload every frame. It is
    // pure data and only ever read after a start has loaded it.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            pat_hold <= bus.pat_in;
        end
    end

    // shreg is cleared whenever no pattern bit is on the line, so dout can be
    // taken directly from its MSB and is 0 in IDLE, GAP and FIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            frames_left <= '0;
            gapcnt      <= '0;
            dvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (state == IDLE) begin
            // abort has no effect here, and start wins over a simultaneous abort
            if (bus.start) begin
                state       <= SHIFT;
                shreg       <= bus.pat_in;
                bitcnt      <= '0;
                frames_left <= (bus.rep_in == '0) ? ONE_FRAME : bus.rep_in;
                gapcnt      <= '0;
                dvalid_q    <= 1'b1;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
            end
        end else if (bus.abort) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            frames_left <= '0;
            gapcnt      <= '0;
            dvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (bitcnt == LAST_BIT) begin
                        bitcnt <= '0;
                        if (frames_left > ONE_FRAME) begin
                            frames_left <= frames_left - ONE_FRAME;
                            if (GAP_CYC > 0) begin
                                state    <= GAP;
                                shreg    <= '0;
                                gapcnt   <= '0;
                                dvalid_q <= 1'b0;
                            end else begin
                                // back-to-back frames: no dvalid bubble
                                shreg <= pat_hold;
                            end
                        end else begin
                            state       <= FIN;
                            frames_left <= '0;
                            shreg       <= '0;
                            dvalid_q    <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end else begin
                        shreg  <= shreg << 1;
                        bitcnt <= bitcnt + BC_W'(1);
                    end
                end
                GAP: begin
                    if (gapcnt == GAP_LAST) begin
                        state    <= SHIFT;
                        gapcnt   <= '0;
                        shreg    <= pat_hold;
                        dvalid_q <= 1'b1;
                    end else begin
                        gapcnt <= gapcnt + GC_W'(1);
                    end
                end
                FIN: begin
                    // start seen here is dropped: the request is only sampled in IDLE
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout   = shreg[PAT_W-1];
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: doc/moore_seqgen.md
Name: moore_seqgen

Overview:
- Serial pattern transmitter: the driving end of the serial bit stream that our Moore sequence detectors sample.
- Latches a PAT_W-bit pattern and a frame repeat count on a start request.
- Shifts the pattern out MSB-first, one bit per clock, with programmable idle gaps between frames.
- Handshakes with the testbench or controller through busy/done; used to stimulate detectors in-system.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- REP_W, 4, width of repeat-count input.
- GAP_CYC, 2, idle cycles inserted between consecutive frames (0 allowed = back-to-back).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- pat_in  input  PAT_W  pattern; latched on accepted start.
- rep_in  input  REP_W  number of frames; latched on accepted start; 0 treated as 1.
- abort  input  1  synchronous cancel; effective in any non-IDLE state.
- dout  output  1  serial data bit (registered).
- dvalid  output  1  high while dout carries a pattern bit (registered).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- Reset (reset=0, async): state=IDLE; dout=0, dvalid=0, busy=0, done=0; shift register, bit counter, frame counter and gap counter all 0.
- All outputs are Moore/registered; no combinational path from any input to any output.
- States: IDLE, SHIFT, GAP, FIN.
- IDLE: if start=1 at edge k:
  - load shreg<=pat_in, frames_left<=(rep_in==0 ? 1 : rep_in), bitcnt<=0; go to SHIFT.
  - dout=pat_in[PAT_W-1] and dvalid=1 are visible after edge k (latency 1 cycle).
  - start while busy is ignored; no queuing.
- SHIFT:
  - Each edge: shift left and present the next MSB; bitcnt increments.
  - After PAT_W bits have been presented, decrement frames_left.
  - If frames remain and GAP_CYC>0: go to GAP (dout=0, dvalid=0).
  - If frames remain and GAP_CYC=0: reload the latched pattern and continue SHIFT with no dvalid bubble.
  - If no frames remain: go to FIN.
- GAP: dout=0, dvalid=0 for exactly GAP_CYC cycles, then reload the latched pattern and go to SHIFT.
- FIN: done=1, busy=1, dvalid=0 for exactly one cycle, then IDLE. start sampled during FIN is ignored.
- The original pattern is held in a separate register, so each frame is identical.
- abort=1 in SHIFT/GAP/FIN: next state IDLE; dout=0, dvalid=0, done=0 (no done pulse); counters cleared. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Reset asserted mid-frame: outputs clear immediately (async). After release, the block waits in IDLE for a new start.
- Counters:
  - bitcnt is ceil(log2(PAT_W)) bits, wraps at PAT_W-1.
  - frames_left is REP_W bits and never underflows.
  - gap counter is sized for GAP_CYC.
- Total busy cycles for N frames: N*PAT_W + (N-1)*GAP_CYC + 1.

Test Plan:
- Reset, pat_in=4'b1011, rep_in=1, start pulse -> dout=1,0,1,1 with dvalid=1 for 4 cycles; done=1 on cycle 5; busy high 5 cycles; then IDLE.
- pat_in=4'b1010, rep_in=2, GAP_CYC=2 -> 1,0,1,0, then 2 cycles dout=0/dvalid=0, then 1,0,1,0, then done; 11 busy cycles total.
- rep_in=0 -> behaves exactly as rep_in=1 (single frame, done once).
- abort asserted on the 2nd bit of frame 1 -> next cycle busy=0, dvalid=0, dout=0; no done pulse; a new start is accepted immediately.
- start re-pulsed mid-frame -> ignored, sequence unchanged. reset=0 mid-frame -> all outputs 0 asynchronously, before the next clk edge.
- Loopback: connect dout to the moore_seqnd din, with pat_in=4'b1011 and rep_in=3, GAP_CYC=0 -> detector y pulses at each completed 101 in the stream, matching a golden model.
